// File: rtl/framer_pkg.sv
// Shared types and constants for the BCD-to-ASCII framer.
//   state_e     : frame generator states, in emission order
//   ASC_*       : ASCII codes written into the byte stream
//   LZ_*        : leading-zero handling codes (LZ_MODE parameter)
//   TERM_*      : frame terminator codes (TERM_MODE parameter)
//   digit_char  : maps one BCD nibble to its ASCII character
package framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INT,
      ST_DOT,
      ST_FRAC,
      ST_SUFX,
      ST_TERM
   } state_e;

   localparam logic [7:0] ASC_ZERO  = 8'h30;
   localparam logic [7:0] ASC_DOT   = 8'h2E;
   localparam logic [7:0] ASC_QMARK = 8'h3F;
   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_LF    = 8'h0A;

   localparam int LZ_KEEP  = 0;
   localparam int LZ_SKIP  = 1;
   localparam int LZ_SPACE = 2;

   localparam int TERM_NONE = 0;
   localparam int TERM_LF   = 1;
   localparam int TERM_CRLF = 2;

   // Nibbles above 9 are not decimal digits and are shown as '?'.
   function automatic logic [7:0] digit_char(input logic [3:0] nib);
      logic [7:0] c;
      if (nib > 4'd9) c = ASC_QMARK;
      else            c = ASC_ZERO + {4'd0, nib};
      return c;
   endfunction

endpackage

// File: rtl/bcd_ascii_framer_if.sv
// Byte stream between the framer and its sink (uart_tx or similar).
//   m_data  : ASCII byte, valid while m_valid is high
//   m_valid : source has a byte for the sink
//   m_ready : sink accepts the byte
// Handshake: a byte transfers on a rising clk edge where m_valid && m_ready;
// while m_valid && !m_ready the source holds m_data and m_valid unchanged.
// m_valid does not depend combinationally on m_ready.
interface bcd_ascii_framer_if;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered valid.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en      : push wr_data (accepted when not full, or when full and popping)
//   rd_en      : sink ready; pops the head when rd_valid is high
//   rd_data    : head entry, forced to 0 while rd_valid is low
//   rd_valid   : registered "not empty"
//   full/empty : occupancy flags; level : current occupancy
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             vld_q, vld_d;
   logic             push, pop;

   always_comb begin
      pop      = rd_en && vld_q;
      push     = wr_en && (!full || pop);
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      // A pop retires the head at once, but a new entry only shows up as
      // valid one cycle after it is written.
      vld_d    = (cnt_q - CW'(pop)) != '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         vld_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         vld_q    <= vld_d;
      end
   end

   // Storage is not reset; stale entries are never exposed because rd_data
   // is gated by the valid flag.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data  = vld_q ? mem_q[rd_ptr_q] : '0;
   assign rd_valid = vld_q;
   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign level    = cnt_q;

endmodule

// File: rtl/bcd_ascii_framer.sv
// Formats a packed BCD value as an ASCII frame and streams it out bytewise:
// integer digits (leading zeros kept, skipped or blanked), optional '.' and
// fraction digits, a fixed suffix string and an optional LF / CR LF.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bcd_data     : BCD value, digit DIGITS-1 in the MSBs
//   bcd_vld      : one-cycle strobe qualifying bcd_data
//   m_if         : byte stream to the sink (master side)
//   busy         : frame generator is not idle
//   frame_drop   : pulse, a pending value was overwritten before use
//   bcd_err      : pulse, a nibble > 9 was emitted as '?'
//   fifo_level   : output FIFO occupancy
//   dbg_state    : current frame generator state
module bcd_ascii_framer
   import framer_pkg::*;
#(
   parameter int DIGITS      = 6,
   parameter int FRAC_DIGITS = 2,
   parameter int SUFFIX_LEN  = 2,
   parameter logic [8*((SUFFIX_LEN > 0) ? SUFFIX_LEN : 1)-1:0] SUFFIX = "cm",
   parameter int LZ_MODE     = 1,
   parameter int TERM_MODE   = 2,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [4*DIGITS-1:0]           bcd_data,
   input  logic                          bcd_vld,
   bcd_ascii_framer_if.master            m_if,
   output logic                          busy,
   output logic                          frame_drop,
   output logic                          bcd_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output state_e                        dbg_state
);
   localparam int MAXN      = (DIGITS > SUFFIX_LEN) ? DIGITS : SUFFIX_LEN;
   localparam int IW        = $clog2(MAXN + 1);
   localparam int TERM_LAST = (TERM_MODE == TERM_CRLF) ? 1 : 0;

   // Successor of each state once its last character is done; disabled
   // sections are folded out here so the FSM itself stays fixed.
   localparam state_e ST_AFTER_SUFX = (TERM_MODE != TERM_NONE) ? ST_TERM : ST_IDLE;
   localparam state_e ST_AFTER_FRAC = (SUFFIX_LEN > 0)         ? ST_SUFX : ST_AFTER_SUFX;
   localparam state_e ST_AFTER_INT  = (FRAC_DIGITS > 0)        ? ST_DOT  : ST_AFTER_FRAC;

   state_e               state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 lz_q, lz_d;
   logic [4*DIGITS-1:0]  work_q, work_d;
   logic [4*DIGITS-1:0]  pend_q, pend_d;
   logic                 pend_vld_q, pend_vld_d;
   logic                 drop_q, drop_d;
   logic                 err_q, err_d;

   logic                 wr_req, fifo_wr, fifo_full, fifo_empty_unused;
   logic [7:0]           wr_byte;
   logic                 last, advance, start;
   logic [3:0]           nib;
   state_e               nxt;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      lz_d       = lz_q;
      work_d     = work_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      drop_d     = 1'b0;
      err_d      = 1'b0;
      wr_req     = 1'b0;
      wr_byte    = '0;
      last       = 1'b0;
      start      = 1'b0;
      nxt        = ST_IDLE;
      nib        = work_q[4*int'(idx_q) +: 4];

      case (state_q)
         ST_IDLE: begin
            // A waiting value wins; a same-cycle strobe refills the pending slot.
            if (pend_vld_q) begin
               work_d     = pend_q;
               pend_vld_d = bcd_vld;
               if (bcd_vld) pend_d = bcd_data;
               start      = 1'b1;
            end else if (bcd_vld) begin
               work_d = bcd_data;
               start  = 1'b1;
            end
         end
         ST_INT: begin
            last = (idx_q == IW'(FRAC_DIGITS));
            // The units digit is never suppressed.
            if (lz_q && nib == 4'd0 && !last) begin
               if (LZ_MODE == LZ_SPACE) begin
                  wr_req  = 1'b1;
                  wr_byte = ASC_SPACE;
               end
            end else begin
               wr_req  = 1'b1;
               wr_byte = digit_char(nib);
            end
            nxt = ST_AFTER_INT;
         end
         ST_DOT: begin
            wr_req  = 1'b1;
            wr_byte = ASC_DOT;
            last    = 1'b1;
            nxt     = ST_FRAC;
         end
         ST_FRAC: begin
            wr_req  = 1'b1;
            wr_byte = digit_char(nib);
            last    = (idx_q == '0);
            nxt     = ST_AFTER_FRAC;
         end
         ST_SUFX: begin
            wr_req = 1'b1;
            if (SUFFIX_LEN > 0) wr_byte = SUFFIX[8*(SUFFIX_LEN-1-int'(idx_q)) +: 8];
            last   = (idx_q == IW'(SUFFIX_LEN-1));
            nxt    = ST_AFTER_SUFX;
         end
         ST_TERM: begin
            wr_req  = 1'b1;
            wr_byte = (TERM_MODE == TERM_CRLF && idx_q == '0) ? ASC_CR : ASC_LF;
            last    = (idx_q == IW'(TERM_LAST));
            nxt     = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outside IDLE every strobe lands in the pending slot; hitting an
      // occupied slot loses the older value.
      if (state_q != ST_IDLE && bcd_vld) begin
         pend_d     = bcd_data;
         pend_vld_d = 1'b1;
         drop_d     = pend_vld_q;
      end

      // A character that needs a FIFO slot holds the FSM until one is free.
      fifo_wr = wr_req && !fifo_full;
      advance = (state_q != ST_IDLE) && (!wr_req || !fifo_full);

      if (start) begin
         state_d = ST_INT;
         idx_d   = IW'(DIGITS-1);
         lz_d    = (LZ_MODE != LZ_KEEP);
      end else if (advance) begin
         if (state_q == ST_INT && nib != 4'd0) lz_d = 1'b0;
         err_d = (state_q == ST_INT || state_q == ST_FRAC) && (nib > 4'd9);
         if (last) begin
            state_d = nxt;
            idx_d   = (nxt == ST_FRAC) ? IW'(FRAC_DIGITS-1) : '0;
         end else if (state_q == ST_INT || state_q == ST_FRAC) begin
            idx_d = idx_q - IW'(1);
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         lz_q       <= 1'b0;
         work_q     <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         drop_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         lz_q       <= lz_d;
         work_q     <= work_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (fifo_wr),
      .wr_data  (wr_byte),
      .rd_en    (m_if.m_ready),
      .rd_data  (m_if.m_data),
      .rd_valid (m_if.m_valid),
      .full     (fifo_full),
      .empty    (fifo_empty_unused),
      .level    (fifo_level)
   );

   assign busy       = (state_q != ST_IDLE);
   assign frame_drop = drop_q;
   assign bcd_err    = err_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/bcd_ascii_framer.md
Name: bcd_ascii_framer

Overview:
Parametrised successor to the distance UART formatter. It latches a packed BCD value and emits it as an ASCII frame on a byte stream: integer digits with selectable leading-zero handling, optional decimal point and fraction digits, a unit suffix string, and an optional CR/LF terminator. Bytes are buffered in an internal FIFO and drained over a valid/ready interface into uart_tx, or into any other byte sink.

Parameters:
DIGITS, 6, total BCD digits in bcd_data
FRAC_DIGITS, 2, digits after the decimal point; 0 means no '.' is emitted; must be < DIGITS
SUFFIX_LEN, 2, number of suffix characters; 0 means no suffix
SUFFIX, "cm", 8*SUFFIX_LEN bits; first character in the MSB byte
LZ_MODE, 1, 0 = emit leading zeros, 1 = skip them, 2 = replace them with space (0x20)
TERM_MODE, 2, 0 = none, 1 = LF, 2 = CR LF
FIFO_DEPTH, 16, byte FIFO depth; power of 2, at least 4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
bcd_data  in  4*DIGITS  BCD value; digit DIGITS-1 is in the MSBs
bcd_vld  in  1  one-cycle strobe; bcd_data is valid this cycle
m_data  out  8  ASCII byte to the sink
m_valid  out  1  m_data is valid
m_ready  in  1  sink accepts the byte
busy  out  1  a frame is being generated (FSM not in IDLE)
frame_drop  out  1  one-cycle pulse: a pending value was overwritten
bcd_err  out  1  one-cycle pulse: a nibble > 9 was emitted as '?'
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: all outputs are 0 and the FIFO is empty. FSM goes to IDLE and pending_vld is cleared. Reset mid-frame aborts the frame; no partial bytes remain.
- Capture:
  - In IDLE, pending_vld has priority: the pending value is loaded into the working register.
  - Otherwise, in IDLE, bcd_vld loads bcd_data into the working register.
  - When not in IDLE, bcd_vld writes the pending register.
  - bcd_vld while pending_vld is set overwrites the pending value and pulses frame_drop.
  - In IDLE, if pending is being loaded and bcd_vld arrives in the same cycle, bcd_data goes to pending with no drop.
- FSM states: IDLE -> INT -> DOT -> FRAC -> SUFX -> TERM -> IDLE.
  - Digit index counts down in INT and FRAC; the character index counts in SUFX and TERM.
  - DOT and FRAC are bypassed when FRAC_DIGITS=0. SUFX is bypassed when SUFFIX_LEN=0. TERM is bypassed when TERM_MODE=0.
- Character rules:
  - Digit d maps to 0x30+d.
  - A nibble > 9 maps to 0x3F ('?'), pulses bcd_err, and counts as non-zero for leading-zero handling.
  - '.' is 0x2E, CR is 0x0D, LF is 0x0A.
- Leading zeros:
  - Only integer digits are affected. Suppression ends at the first non-zero integer digit.
  - The last integer digit is always emitted as a digit, so 000005 gives "0.05".
  - LZ_MODE=1: a skipped digit takes one cycle with no FIFO write.
  - LZ_MODE=2: a skipped digit is written as 0x20.
- Timing:
  - One state step per cycle. A step that writes occurs only if the FIFO is not full.
  - FIFO full stalls the FSM on the current character; no byte is lost or duplicated.
  - bcd_vld sampled at edge N gives the first FIFO write at edge N+1 (no skip) and m_valid high after edge N+2.
  - After TERM, or the last enabled state, the FSM returns to IDLE in the next cycle. Back-to-back frames therefore have one IDLE cycle between them.
- Output handshake:
  - A byte transfers when m_valid && m_ready.
  - m_data and m_valid are held stable while m_valid && !m_ready.
  - m_valid = FIFO not empty, registered.
  - FIFO write and read in the same cycle when full is permitted; level is unchanged.
- Frame length with defaults: int(1..4) + 1 + 2 + 2 + 2.

Decomposition:
- Package framer_pkg:
  - state enum (IDLE, INT, DOT, FRAC, SUFX, TERM)
  - ASCII constants (ZERO=0x30, DOT=0x2E, QMARK=0x3F, SPACE=0x20, CR=0x0D, LF=0x0A)
  - LZ_MODE codes and TERM_MODE codes
- One sub-module: sync_fifo.
  - Parameters WIDTH=8 and DEPTH.
  - First-word-fall-through output with registered valid.
  - Provides full, empty and level.

Test Plan:
- Defaults, bcd_data=0x000123, m_ready=1 -> bytes 31 2E 32 33 63 6D 0D 0A; busy low 1 cycle after the last FIFO write.
- LZ_MODE=2, bcd_data=0x000005 -> 20 20 20 30 2E 30 35 63 6D 0D 0A.
- bcd_data=0x12A456 -> 31 32 3F 34 2E 35 36 ...; bcd_err pulses once; 'A' counts as a non-zero digit.
- m_ready=0 for 40 cycles -> fifo_level saturates at 16 and the FSM stalls; m_data is stable. On m_ready=1 all bytes arrive in order with no loss.
- Three bcd_vld pulses during one frame -> frame_drop pulses once (3rd overwrites 2nd); frames 1 and 3 are emitted, frame 2 is absent.
- rst_n low mid-frame -> m_valid=0 and fifo_level=0 immediately. After release, a new bcd_vld produces a clean full frame.
